// File: rtl/hoeraa.sv
// HOERAA approximate adder: exact ripple-carry upper part, OR-based lower part
// with a single-bit error-reduction term, registered with one cycle of latency.
module hoeraa #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         out_valid
);

    logic         cin;
    logic         g;
    logic         co_c;
    logic [N-1:0] sum_c;
    logic [N-K:0] carry;

    always_comb begin
        sum_c = '0;
        carry = '0;
        cin   = X[K-1] & Y[K-1];
        g     = X[K-2] & Y[K-2];

        // Lower part: no carry chain; G saturates the bits below K-1.
        sum_c[K-1] = (X[K-1] ^ Y[K-1]) | g;
        for (int unsigned i = 0; i < K - 1; i++) begin
            sum_c[i] = X[i] | Y[i] | g;
        end

        carry[0] = cin;
        for (int unsigned i = 0; i < N - K; i++) begin
            sum_c[K+i]  = X[K+i] ^ Y[K+i] ^ carry[i];
            carry[i+1]  = (X[K+i] & Y[K+i]) | (carry[i] & (X[K+i] ^ Y[K+i]));
        end
        co_c = carry[N-K];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= '0;
            Co        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S  <= sum_c;
                Co <= co_c;
            end
        end
    end

endmodule

// File: tb/tb_hoeraa.sv
// Directed and random stimulus for hoeraa (N=16, K=7) checked with immediate assertions.
module tb_hoeraa;

    localparam int unsigned N = 16;
    localparam int unsigned K = 7;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [N-1:0]  s;
    logic          co;
    logic          out_valid;

    int total;
    int bad;

    hoeraa #(.N(N), .K(K)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .X(x),
        .Y(y),
        .S(s),
        .Co(co),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference built directly from the operation equations (N=16, K=7).
    function automatic logic [N:0] model(input logic [15:0] a, input logic [15:0] b);
        logic       c_in;
        logic       gg;
        logic       s6;
        logic [5:0] low;
        logic [9:0] up;
        c_in = a[6] & b[6];
        gg   = a[5] & b[5];
        s6   = (a[6] ^ b[6]) | gg;
        low  = gg ? 6'h3F : (a[5:0] | b[5:0]);
        up   = {1'b0, a[15:7]} + {1'b0, b[15:7]} + {9'd0, c_in};
        return {up, s6, low};
    endfunction

    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic ec);
        @(negedge clk);
        in_valid = 1'b1;
        x = a;
        y = b;
        @(posedge clk);
        #1;
        check({tag, "_s"}, s, es);
        check({tag, "_co"}, {15'd0, co}, {15'd0, ec});
        check({tag, "_vld"}, {15'd0, out_valid}, 16'd1);
    endtask

    initial begin
        logic [N:0]   m;
        logic [N-1:0] exp_s;
        logic         exp_co;
        logic         exp_v;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_s", s, 16'h0000);
        check("rst_co", {15'd0, co}, 16'd0);
        check("rst_vld", {15'd0, out_valid}, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_s", s, 16'h0000);
        check("idle_co", {15'd0, co}, 16'd0);
        check("idle_vld", {15'd0, out_valid}, 16'd0);

        step("one_one", 16'h0001, 16'h0001, 16'h0001, 1'b0);
        step("ff_ff", 16'h00FF, 16'h00FF, 16'h01FF, 1'b0);
        step("max_max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        step("alt", 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0);
        step("mixed", 16'h8001, 16'h0101, 16'h8101, 1'b0);

        @(negedge clk);
        in_valid = 1'b0;
        x = 16'h1234;
        y = 16'h4321;
        @(posedge clk);
        #1;
        check("hold_s", s, 16'h8101);
        check("hold_co", {15'd0, co}, 16'd0);
        check("hold_vld", {15'd0, out_valid}, 16'd0);

        // Mid-stream reset: clears between edges.
        step("pre_rst", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_s", s, 16'h0000);
        check("async_co", {15'd0, co}, 16'd0);
        check("async_vld", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s", s, 16'h0000);
        check("post_rst_vld", {15'd0, out_valid}, 16'd0);

        exp_s  = '0;
        exp_co = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 10 == 3) begin
                x = 16'hFFFF;
                y = 16'h0040;
            end
            m = model(x, y);
            exp_v = in_valid;
            if (in_valid) begin
                exp_s  = m[N-1:0];
                exp_co = m[N];
            end
            @(posedge clk);
            #1;
            check("rnd_s", s, exp_s);
            check("rnd_co", {15'd0, co}, {15'd0, exp_co});
            check("rnd_vld", {15'd0, out_valid}, {15'd0, exp_v});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
